// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq
// Reset sequencer sitting between the clock manager and the DPU in the FPGA top.
// Combines board reset, clock-manager lock, a debounced push-button and a host
// soft-reset pulse into two staged, SYS_CLK-synchronous deasserting resets:
// BUS_RST_N (interconnect/memory) releases first, CORE_RST_N follows after a gap.
// Once running, lock loss, button or soft request re-enter the sequence; the last
// cause and a saturating re-entry count are kept for the host.
//
// Interface semantics: there is no valid/ready handshake on this block. SW_RST_REQ
// is a one-cycle, SYS_CLK-synchronous request pulse; it is acted on only when the
// sequencer is in REL_BUS or RUN and silently dropped in any other state. All other
// inputs are level signals sampled through synchronizers.
//
// dbg_state mirrors the FSM state register for checkers and waveform viewing:
//   0 ASSERT, 1 WAIT_LOCK, 2 HOLD, 3 REL_BUS, 4 RUN.

module fpga_rst_seq #(
  parameter int P_SYNC_STAGES  = 2,
  parameter int P_DEBOUNCE_CYC = 1000,
  parameter int P_HOLD_CYC     = 16,
  parameter int P_STAGE_GAP    = 8
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST_N,
  input  logic       SYS_CLK_STABLE,
  input  logic       BOARD_RST_SW,
  input  logic       SW_RST_REQ,
  output logic       BUS_RST_N,
  output logic       CORE_RST_N,
  output logic       RST_DONE,
  output logic [1:0] RST_CAUSE,
  output logic [7:0] RST_COUNT,
  output logic [2:0] dbg_state
);

  // FSM encoding
  localparam logic [2:0] ST_ASSERT    = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_REL_BUS   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  // Reset cause encoding
  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_SOFT = 2'b11;

  // One shared down-path counter serves both HOLD and REL_BUS, so it is sized
  // for whichever of the two intervals is longer.
  localparam int CNT_MAX = (P_HOLD_CYC > P_STAGE_GAP) ? P_HOLD_CYC : P_STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(P_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(P_STAGE_GAP - 1);

  localparam int DEB_W = (P_DEBOUNCE_CYC > 1) ? $clog2(P_DEBOUNCE_CYC + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(P_DEBOUNCE_CYC - 1);

  // Synchronizer chains; the last flop of each chain is the usable signal.
  logic [P_SYNC_STAGES-1:0] stable_sync;
  logic [P_SYNC_STAGES-1:0] sw_sync;
  logic                     stable_s;
  logic                     sw_s;

  // Debounce state
  logic [DEB_W-1:0] deb_cnt;
  logic             sw_deb;

  // FSM state and interval counter
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Re-entry trigger decode and bookkeeping next values
  logic       trig;
  logic [1:0] trig_cause;
  logic [1:0] cause_nxt;
  logic [7:0] count_nxt;
  logic [7:0] count_inc;

  assign stable_s  = stable_sync[P_SYNC_STAGES-1];
  assign sw_s      = sw_sync[P_SYNC_STAGES-1];
  assign dbg_state = state;

  // Bring the asynchronous lock and button levels into the SYS_CLK domain.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      stable_sync <= '0;
      sw_sync     <= '0;
    end else begin
      stable_sync <= {stable_sync[P_SYNC_STAGES-2:0], SYS_CLK_STABLE};
      sw_sync     <= {sw_sync[P_SYNC_STAGES-2:0], BOARD_RST_SW};
    end
  end

  // Debounce: flip sw_deb only after sw_s has disagreed with it for
  // P_DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      deb_cnt <= '0;
      sw_deb  <= 1'b0;
    end else if (sw_s != sw_deb) begin
      if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        sw_deb  <= sw_s;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Trigger decode with fixed priority: lock loss, then button, then soft request.
  always_comb begin
    trig       = 1'b0;
    trig_cause = CAUSE_POR;
    if (!stable_s) begin
      trig       = 1'b1;
      trig_cause = CAUSE_LOCK;
    end else if (sw_deb) begin
      trig       = 1'b1;
      trig_cause = CAUSE_BTN;
    end else if (SW_RST_REQ) begin
      trig       = 1'b1;
      trig_cause = CAUSE_SOFT;
    end
  end

  assign count_inc = (RST_COUNT == 8'hFF) ? 8'hFF : (RST_COUNT + 8'd1);

  // Next-state logic for the sequencer, interval counter, cause and count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = RST_CAUSE;
    count_nxt = RST_COUNT;
    case (state)
      ST_ASSERT: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
      ST_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (stable_s && !sw_deb) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Losing lock or a pressed button restarts the wait from scratch.
        if (!stable_s || sw_deb) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_REL_BUS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_REL_BUS: begin
        if (trig) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
          cause_nxt = trig_cause;
          count_nxt = count_inc;
        end else if (cnt == GAP_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (trig) begin
          state_nxt = ST_ASSERT;
          cause_nxt = trig_cause;
          count_nxt = count_inc;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and bookkeeping registers.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      RST_CAUSE <= CAUSE_POR;
      RST_COUNT <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      RST_CAUSE <= cause_nxt;
      RST_COUNT <= count_nxt;
    end
  end

  // Reset outputs are registered from the next state so they change on the same
  // edge as the state and can never glitch high between stages.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      BUS_RST_N  <= 1'b0;
      CORE_RST_N <= 1'b0;
      RST_DONE   <= 1'b0;
    end else begin
      BUS_RST_N  <= (state_nxt == ST_REL_BUS) || (state_nxt == ST_RUN);
      CORE_RST_N <= (state_nxt == ST_RUN);
      RST_DONE   <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb_fpga_rst_seq
// Directed bench for fpga_rst_seq with P_DEBOUNCE_CYC=8 and the other parameters
// at their defaults. Edge counts below are hand-derived from the sequencing rules.

module tb_fpga_rst_seq;

  localparam logic [2:0] ST_ASSERT    = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_REL_BUS   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  logic       clk;
  logic       rst_n;
  logic       stable;
  logic       sw;
  logic       req;
  logic       bus_rst_n;
  logic       core_rst_n;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;
  logic [2:0] dbg_state;

  int n_cmp;
  int n_err;
  int model_cnt;
  int n;

  // Expected {cause, count} after each re-entry trigger
  logic [9:0] exp_q[$];

  fpga_rst_seq #(
    .P_SYNC_STAGES (2),
    .P_DEBOUNCE_CYC(8),
    .P_HOLD_CYC    (16),
    .P_STAGE_GAP   (8)
  ) dut (
    .SYS_CLK       (clk),
    .SYS_RST_N     (rst_n),
    .SYS_CLK_STABLE(stable),
    .BOARD_RST_SW  (sw),
    .SW_RST_REQ    (req),
    .BUS_RST_N     (bus_rst_n),
    .CORE_RST_N    (core_rst_n),
    .RST_DONE      (rst_done),
    .RST_CAUSE     (rst_cause),
    .RST_COUNT     (rst_count),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

  // Checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return bus_rst_n;
      1:       return core_rst_n;
      default: return rst_done;
    endcase
  endfunction

  // Count edges until the selected output reaches val; -1 if the budget expires.
  task automatic wait_for(input int sel, input logic val, input int max_edges, output int cnt_out);
    cnt_out = -1;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk);
      #1;
      if (get_sig(sel) === val) begin
        cnt_out = k;
        break;
      end
    end
  endtask

  // Scoreboard helpers
  task automatic expect_trigger(input logic [1:0] cause);
    if (model_cnt < 255) model_cnt++;
    exp_q.push_back({cause, 8'(model_cnt)});
  endtask

  task automatic check_trigger(input string tag);
    logic [9:0] exp;
    exp = exp_q.pop_front();
    check(tag, {22'd0, rst_cause, rst_count}, {22'd0, exp});
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_bus"},   bus_rst_n,  0);
    check({tag, "_core"},  core_rst_n, 0);
    check({tag, "_done"},  rst_done,   0);
    check({tag, "_cause"}, rst_cause,  0);
    check({tag, "_count"}, rst_count,  0);
    check({tag, "_state"}, dbg_state,  ST_ASSERT);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    model_cnt = 0;
    rst_n     = 1'b1;
    stable    = 1'b1;
    sw        = 1'b0;
    req       = 1'b0;

    // 1 Power-on with lock already present
    #1 rst_n = 1'b0;
    #1 check_all_low("por_reset");
    tick(2);
    rst_n = 1'b1;
    wait_for(0, 1'b1, 100, n);
    check("po_bus_edge", n, 19);
    check("po_core_low", core_rst_n, 0);
    wait_for(1, 1'b1, 50, n);
    check("po_core_gap", n, 8);
    check("po_done", rst_done, 1);
    check("po_cause", rst_cause, 0);
    check("po_count", rst_count, 0);
    check("po_state", dbg_state, ST_RUN);

    // 2 Late lock: asynchronous reset, then lock arrives 50 cycles after release
    rst_n  = 1'b0;
    stable = 1'b0;
    #1 check_all_low("late_reset");
    model_cnt = 0;
    tick(1);
    rst_n = 1'b1;
    tick(50);
    check("late_wait_state", dbg_state, ST_WAIT_LOCK);
    check("late_wait_bus", bus_rst_n, 0);
    stable = 1'b1;
    wait_for(0, 1'b1, 100, n);
    check("late_bus_edge", n, 19);
    wait_for(1, 1'b1, 50, n);
    check("late_core_gap", n, 8);

    // 3 One-cycle lock loss in RUN
    stable = 1'b0;
    tick(1);
    stable = 1'b1;
    check("ll_e1_bus", bus_rst_n, 1);
    tick(1);
    check("ll_e2_bus", bus_rst_n, 1);
    tick(1);
    expect_trigger(2'b01);
    check("ll_e3_bus", bus_rst_n, 0);
    check("ll_e3_core", core_rst_n, 0);
    check("ll_e3_done", rst_done, 0);
    check_trigger("ll_trig");
    wait_for(0, 1'b1, 100, n);
    check("ll_rebus", n, 18);
    wait_for(1, 1'b1, 50, n);
    check("ll_recore", n, 8);

    // 4 Button: short pulse filtered, long press resets until released
    sw = 1'b1;
    tick(5);
    sw = 1'b0;
    tick(20);
    check("btn_short_bus", bus_rst_n, 1);
    check("btn_short_state", dbg_state, ST_RUN);
    check("btn_short_count", rst_count, 1);
    sw = 1'b1;
    wait_for(0, 1'b0, 40, n);
    expect_trigger(2'b10);
    check("btn_press_edge", n, 11);
    check_trigger("btn_trig");
    tick(20 - n);
    check("btn_held_state", dbg_state, ST_WAIT_LOCK);
    sw = 1'b0;
    tick(10);
    check("btn_rel_state", dbg_state, ST_WAIT_LOCK);
    wait_for(0, 1'b1, 60, n);
    check("btn_rebus", n, 17);
    wait_for(1, 1'b1, 50, n);
    check("btn_recore", n, 8);

    // 5a Soft request in RUN
    req = 1'b1;
    tick(1);
    req = 1'b0;
    expect_trigger(2'b11);
    check("soft_bus", bus_rst_n, 0);
    check_trigger("soft_trig");
    wait_for(0, 1'b1, 60, n);
    check("soft_rebus", n, 18);
    wait_for(1, 1'b1, 50, n);
    check("soft_recore", n, 8);

    // 5b Soft request on the same edge lock loss is detected
    stable = 1'b0;
    tick(1);
    stable = 1'b1;
    tick(1);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    expect_trigger(2'b01);
    check("sim_bus", bus_rst_n, 0);
    check_trigger("sim_trig");

    // 5c Soft request during HOLD is ignored
    tick(3);
    check("hold_state", dbg_state, ST_HOLD);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    check("hold_ign_state", dbg_state, ST_HOLD);
    check("hold_ign_cc", {22'd0, rst_cause, rst_count}, {22'd0, 2'b01, 8'(model_cnt)});
    wait_for(0, 1'b1, 60, n);
    check("hold_rebus", n, 14);

    // 6a 300 soft requests saturate the count
    for (int i = 0; i < 300; i++) begin
      req = 1'b1;
      tick(1);
      req = 1'b0;
      expect_trigger(2'b11);
      check_trigger("sat_trig");
      wait_for(0, 1'b1, 40, n);
      check("sat_rebus", n, 18);
    end
    check("sat_count", rst_count, 255);

    // 6b Asynchronous reset during REL_BUS
    tick(2);
    check("rel_state", dbg_state, ST_REL_BUS);
    check("rel_core", core_rst_n, 0);
    #2 rst_n = 1'b0;
    #1 check_all_low("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
